// File: rtl/product_accumulator_pkg.sv
// Shared types and defaults for the product accumulator.
// Holds the FSM state encoding and default datapath widths.
package product_accumulator_pkg;

  localparam int IN_W_DEF  = 32;
  localparam int ACC_W_DEF = 40;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/product_accumulator_sat_add.sv
// sat_add: unsigned saturating adder, ACC_W-bit a plus IN_W-bit b.
// Ports: a, b in; sum (clamped to all-ones), sat (clamp happened) out.
module sat_add
  import product_accumulator_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a,
  input  logic [IN_W-1:0]  b,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);

  // One extra bit catches the carry out of the ACC_W-bit sum.
  logic [ACC_W:0] wide;

  always_comb begin
    wide = {1'b0, a} + (ACC_W+1)'(b);
    sat  = wide[ACC_W];
    sum  = sat ? '1 : wide[ACC_W-1:0];
  end

endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums a run of len products with saturation.
// Ports: start/len begin a run; in_valid/in_ready take products;
// out_valid/out_ready return acc_out + overflow; busy = run active.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic             busy
);

  state_e state_q, state_d;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             rovf_q, rovf_d;

  logic [ACC_W-1:0] sum;
  logic             sat;
  logic             accept;
  logic             last;
  logic             out_hs;
  logic             take_start;

  sat_add #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_sat_add (
    .a   (acc_q),
    .b   (product),
    .sum (sum),
    .sat (sat)
  );

  assign accept = in_valid & (state_q == ST_ACCUM);
  assign out_hs = out_ready & (state_q == ST_DONE);
  assign last   = (cnt_q == (len_q - CNT_W'(1)));

  // A start only counts from IDLE or alongside the result handshake.
  assign take_start =
    start & ((state_q == ST_IDLE) | out_hs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (len == '0) ? ST_DONE
                                : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept && last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          if (!start) begin
            state_d = ST_IDLE;
          end else if (len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_ACCUM);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
  end

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    len_d  = len_q;
    ovf_d  = ovf_q;
    res_d  = res_q;
    rovf_d = rovf_q;
    if (take_start) begin
      len_d = len;
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      // An empty run reports zero straight away.
      if (len == '0) begin
        res_d  = '0;
        rovf_d = 1'b0;
      end
    end else if (accept) begin
      acc_d = sum;
      cnt_d = cnt_q + CNT_W'(1);
      ovf_d = ovf_q | sat;
      // Result registers load with the final term so they
      // stay frozen for the whole DONE phase.
      if (last) begin
        res_d  = sum;
        rovf_d = ovf_q | sat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      len_q  <= '0;
      ovf_q  <= 1'b0;
      res_q  <= '0;
      rovf_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      ovf_q  <= ovf_d;
      res_q  <= res_d;
      rovf_q <= rovf_d;
    end
  end

  assign acc_out  = res_q;
  assign overflow = rovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator.
// Runs a 40-bit and a 33-bit accumulator side by side on shared stimulus.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [31:0] product;
  logic        out_ready;

  logic        ir_a, ov_a, of_a, bz_a;
  logic [39:0] acc_a;
  logic        ir_b, ov_b, of_b, bz_b;
  logic [32:0] acc_b;

  int errors = 0;
  int checks = 0;

  logic [31:0] prods[256];

  always #5 clk = ~clk;

  product_accumulator #(
    .IN_W(32), .ACC_W(40), .CNT_W(8)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(ir_a),
    .product(product), .out_valid(ov_a),
    .out_ready(out_ready), .acc_out(acc_a),
    .overflow(of_a), .busy(bz_a)
  );

  product_accumulator #(
    .IN_W(32), .ACC_W(33), .CNT_W(8)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(ir_b),
    .product(product), .out_valid(ov_b),
    .out_ready(out_ready), .acc_out(acc_b),
    .overflow(of_b), .busy(bz_b)
  );

  typedef struct {
    int          n;
    int          gap;
    int          hold;
    bit          poke;
    logic [31:0] p0, p1, p2;
    logic [63:0] e40;
    bit          o40;
    logic [63:0] e33;
    bit          o33;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string nm, input bit ir,
                         input bit ov, input bit bz);
    chk({nm, ".in_ready_a"}, 64'(ir_a), 64'(ir));
    chk({nm, ".out_valid_a"}, 64'(ov_a), 64'(ov));
    chk({nm, ".busy_a"}, 64'(bz_a), 64'(bz));
    chk({nm, ".in_ready_b"}, 64'(ir_b), 64'(ir));
    chk({nm, ".out_valid_b"}, 64'(ov_b), 64'(ov));
    chk({nm, ".busy_b"}, 64'(bz_b), 64'(bz));
  endtask

  task automatic chk_zero(input string nm);
    chk_ctl(nm, 1'b0, 1'b0, 1'b0);
    chk({nm, ".acc_a"}, 64'(acc_a), 64'd0);
    chk({nm, ".ovf_a"}, 64'(of_a), 64'd0);
    chk({nm, ".acc_b"}, 64'(acc_b), 64'd0);
    chk({nm, ".ovf_b"}, 64'(of_b), 64'd0);
  endtask

  // Behavioural model: plain sum of the run, clamped to the width.
  function automatic logic [63:0] msum(input int n);
    logic [63:0] s = 64'd0;
    for (int i = 0; i < n; i++) s += 64'(prods[i]);
    return s;
  endfunction

  function automatic logic [63:0] wmax(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] clampw(input logic [63:0] s,
                                         input int w);
    return (s > wmax(w)) ? wmax(w) : s;
  endfunction

  task automatic after_start(input int n);
    chk_ctl("start", n != 0, n == 0, 1'b1);
  endtask

  task automatic begin_run(input int n);
    start = 1'b1;
    len   = 8'(n);
    tick();
    start = 1'b0;
    len   = 8'd0;
    after_start(n);
  endtask

  // Feed terms [0,cnt) of an n-term run; gap idle cycles between terms.
  task automatic feed(input int n, input int cnt,
                      input int gap, input bit poke);
    for (int i = 0; i < cnt; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          if (poke && g == 0) begin
            start = 1'b1;
            len   = 8'd1;
          end
          tick();
          start = 1'b0;
          chk_ctl("gap", 1'b1, 1'b0, 1'b1);
        end
      end
      in_valid = 1'b1;
      product  = prods[i];
      chk("ready_a", 64'(ir_a), 64'd1);
      chk("ready_b", 64'(ir_b), 64'd1);
      tick();
      in_valid = 1'b0;
      chk_ctl("accept", i != n - 1, i == n - 1, 1'b1);
    end
  endtask

  task automatic finish(input int hold,
                        input logic [63:0] e40, input bit o40,
                        input logic [63:0] e33, input bit o33,
                        input bit chain, input int next_n);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start     = (h == 0);
      len       = 8'd5;
      in_valid  = 1'b1;
      product   = 32'hFFFF_FFFF;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      chk_ctl("hold", 1'b0, 1'b1, 1'b1);
      chk("hold_acc_a", 64'(acc_a), e40);
      chk("hold_acc_b", 64'(acc_b), e33);
    end
    chk("acc_a", 64'(acc_a), e40);
    chk("ovf_a", 64'(of_a), 64'(o40));
    chk("acc_b", 64'(acc_b), e33);
    chk("ovf_b", 64'(of_b), 64'(o33));
    out_ready = 1'b1;
    start     = chain;
    len       = 8'(next_n);
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    len       = 8'd0;
    if (chain) after_start(next_n);
    else chk_ctl("idle", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{3, 0, 0, 1'b0, 32'd6, 32'd50, 32'd65025,
               64'd65081, 1'b0, 64'd65081, 1'b0};
    tbl[1] = '{2, 3, 4, 1'b0, 32'd100, 32'd200, 32'd0,
               64'd300, 1'b0, 64'd300, 1'b0};
    tbl[2] = '{3, 0, 1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 64'h2_FFFF_FFFD, 1'b0,
               64'h1_FFFF_FFFF, 1'b1};
    tbl[3] = '{2, 0, 0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'd0, 64'h1_FFFF_FFFE, 1'b0,
               64'h1_FFFF_FFFE, 1'b0};
    tbl[4] = '{0, 0, 2, 1'b0, 32'd0, 32'd0, 32'd0,
               64'd0, 1'b0, 64'd0, 1'b0};
    tbl[5] = '{3, 1, 0, 1'b1, 32'd7, 32'd8, 32'd9,
               64'd24, 1'b0, 64'd24, 1'b0};

    rst = 1'b1; start = 1'b0; len = 8'd0;
    in_valid = 1'b0; product = 32'd0; out_ready = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    for (int t = 0; t < 6; t++) begin
      prods[0] = tbl[t].p0;
      prods[1] = tbl[t].p1;
      prods[2] = tbl[t].p2;
      begin_run(tbl[t].n);
      feed(tbl[t].n, tbl[t].n, tbl[t].gap, tbl[t].poke);
      finish(tbl[t].hold, tbl[t].e40, tbl[t].o40,
             tbl[t].e33, tbl[t].o33, 1'b0, 0);
    end

    // Start in the same cycle as the handshake, then chain to len 0.
    prods[0] = 32'd1;
    prods[1] = 32'd2;
    begin_run(2);
    feed(2, 2, 0, 1'b0);
    finish(0, 64'd3, 1'b0, 64'd3, 1'b0, 1'b1, 1);
    prods[0] = 32'd7;
    feed(1, 1, 0, 1'b0);
    finish(0, 64'd7, 1'b0, 64'd7, 1'b0, 1'b1, 0);
    finish(1, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 0);

    // Reset in the middle of a 4-term run.
    prods[0] = 32'd11;
    prods[1] = 32'd22;
    begin_run(4);
    feed(4, 2, 0, 1'b0);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    tick();
    rst = 1'b0;
    tick();
    chk_zero("postrst");
    prods[0] = 32'd9;
    begin_run(1);
    feed(1, 1, 0, 1'b0);
    finish(0, 64'd9, 1'b0, 64'd9, 1'b0, 1'b0, 0);

    // Randomized runs against the model.
    for (int r = 0; r < 30; r++) begin
      int n, gap, hold;
      bit poke;
      logic [63:0] s;
      n    = $urandom_range(0, 12);
      gap  = $urandom_range(0, 2);
      hold = $urandom_range(0, 2);
      poke = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < n; i++) begin
        prods[i] = ($urandom_range(0, 3) == 0) ?
                   32'hFFFF_FFFF : $urandom;
      end
      s = msum(n);
      begin_run(n);
      feed(n, n, gap, poke);
      finish(hold, clampw(s, 40), s > wmax(40),
             clampw(s, 33), s > wmax(33), 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
